// File: rtl/det010_rr_sched_if.sv
// Bus between the serial requesters / readback logic and the shared
// 0-1-0 detector scheduler. The requester side drives bits, requests and
// clears. The scheduler side returns grants, match pulses and counter values.
interface det010_rr_sched_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  bit_in;
    logic [N_CH-1:0]  clr;
    logic [N_CH-1:0]  gnt;
    logic             match_valid;
    logic [IDX_W-1:0] match_ch;
    logic [IDX_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_cnt;

    modport master (
        output req, bit_in, clr, rd_sel,
        input  gnt, match_valid, match_ch, rd_cnt
    );

    modport slave (
        input  req, bit_in, clr, rd_sel,
        output gnt, match_valid, match_ch, rd_cnt
    );
endinterface

// File: rtl/det010_rr_sched.sv
// Time-shared 0-1-0 serial pattern detector. Each channel keeps a 2-bit
// detector context and a saturating match counter. A round-robin arbiter
// picks one requesting channel per cycle. A single next-state/match
// datapath, muxed by the grant index, advances that channel's context.
module det010_rr_sched #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input logic               clock,
    input logic               reset_L,
    det010_rr_sched_if.slave  bus
);
    localparam int IDX_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,   // no progress
        S0   = 2'b01,   // last bit 0
        S01  = 2'b10,   // last bits 0,1
        S010 = 2'b11    // last bits 0,1,0 (match)
    } ctx_t;

    // Detector transition for one accepted bit; overlapping matches allowed.
    function automatic ctx_t next_ctx(input ctx_t cur, input logic b);
        case (cur)
            IDLE:    return b ? IDLE : S0;
            S0:      return b ? S01  : S0;
            S01:     return b ? IDLE : S010;
            S010:    return b ? S01  : S0;
            default: return IDLE;
        endcase
    endfunction

    // Channel index arithmetic modulo N_CH (N_CH need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return IDX_W'(s);
    endfunction

    ctx_t             ctx [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [IDX_W-1:0] ptr;
    logic [N_CH-1:0]  eligible;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    ctx_t             nxt;
    logic             hit;
    logic             match_valid_q;
    logic [IDX_W-1:0] match_ch_q;

    // A channel being cleared this cycle does not compete for the detector.
    assign eligible = bus.req & ~bus.clr;

    // Round-robin search: first eligible channel at or after ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!gnt_any && eligible[wrap_add(ptr, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_add(ptr, i);
            end
        end
    end

    // One-hot grant, held off entirely while reset is asserted.
    always_comb begin
        bus.gnt = '0;
        if (gnt_any && reset_L) bus.gnt[gnt_idx] = 1'b1;
    end

    // Shared datapath: the granted channel's context and bit only.
    assign nxt = next_ctx(ctx[gnt_idx], bus.bit_in[gnt_idx]);
    assign hit = gnt_any && (nxt == S010);

    // Per-channel context/counter update, pointer advance and match pulse.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            // NOTE: the context and counter arrays are a handful of flops, not RAM, and must start clean, so they take the async reset.
            for (int i = 0; i < N_CH; i++) begin
                ctx[i] <= IDLE;
                cnt[i] <= '0;
            end
            ptr           <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
            match_valid_q <= hit;
            if (hit) match_ch_q <= gnt_idx;
            if (gnt_any) begin
                ctx[gnt_idx] <= nxt;
                ptr          <= wrap_add(gnt_idx, 1);
                if (hit && (cnt[gnt_idx] != CNT_MAX))
                    cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
            end
            // A cleared channel is never granted, so this cannot collide with the update above.
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clr[i]) begin
                    ctx[i] <= IDLE;
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_ch    = match_ch_q;
    assign bus.rd_cnt      = (int'(bus.rd_sel) < N_CH) ? cnt[bus.rd_sel] : '0;
endmodule

// File: tb/tb_det010_rr_sched.sv
// Bench for det010_rr_sched. The reference model keeps each channel's
// accepted-bit history and declares a match when the last three accepted
// bits are 0,1,0. Arbitration is modelled as a cyclic search from a pointer.
module tb_det010_rr_sched;
    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic clock;
    logic reset_L;

    det010_rr_sched_if #(.N_CH(N), .CNT_W(8)) bus ();
    det010_rr_sched_if #(.N_CH(N), .CNT_W(2)) sbus ();

    det010_rr_sched #(.N_CH(N), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus)
    );

    det010_rr_sched #(.N_CH(N), .CNT_W(2)) dut_sat (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (sbus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Reference model state.
    int ptr_m;
    int exp_ch;
    int cnt_m [N];
    bit hist  [N][$];

    task automatic model_reset();
        ptr_m  = 0;
        exp_ch = 0;
        for (int i = 0; i < N; i++) begin
            cnt_m[i] = 0;
            hist[i].delete();
        end
    endtask

    // Enter reset with a clean model; leaves time at posedge+1 with reset released.
    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_L = 1'b1;
    endtask

    // One clock cycle on the main DUT: drive, check grant, model, clock, check results.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] c);
        int g;
        int sel;
        logic [N-1:0] eg;
        bit exp_mv;
        sel = int'($urandom_range(0, N - 1));
        bus.req    = r;
        bus.bit_in = b;
        bus.clr    = c;
        bus.rd_sel = IDX_W'(sel);
        #1;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr_m + i) % N;
            if (g < 0 && r[j] && !c[j]) g = j;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        total++;
        if (bus.gnt !== eg) begin
            bad++;
            $display("FAIL gnt: got %b expected %b (t=%0t)", bus.gnt, eg, $time);
        end
        exp_mv = 1'b0;
        if (g >= 0) begin
            hist[g].push_back(b[g]);
            if (hist[g].size() > 3) void'(hist[g].pop_front());
            if (hist[g].size() == 3 && hist[g][0] == 1'b0 && hist[g][1] == 1'b1 && hist[g][2] == 1'b0) begin
                exp_mv = 1'b1;
                exp_ch = g;
                if (cnt_m[g] < 255) cnt_m[g]++;
            end
            ptr_m = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                hist[i].delete();
                cnt_m[i] = 0;
            end
        end
        @(posedge clock);
        #1;
        if (bus.match_valid === 1'b1) pulses++;
        total++;
        if (bus.match_valid !== exp_mv) begin
            bad++;
            $display("FAIL match_valid: got %b expected %b (t=%0t)", bus.match_valid, exp_mv, $time);
        end
        total++;
        if (bus.match_ch !== IDX_W'(exp_ch)) begin
            bad++;
            $display("FAIL match_ch: got %0d expected %0d (t=%0t)", bus.match_ch, exp_ch, $time);
        end
        total++;
        if (bus.rd_cnt !== 8'(cnt_m[sel])) begin
            bad++;
            $display("FAIL rd_cnt[%0d]: got %0d expected %0d (t=%0t)", sel, bus.rd_cnt, cnt_m[sel], $time);
        end
    endtask

    task automatic check_cnt(input int ch, input int expv, input string name);
        bus.rd_sel = IDX_W'(ch);
        #1;
        total++;
        if (bus.rd_cnt !== 8'(expv)) begin
            bad++;
            $display("FAIL %s: rd_cnt[%0d] got %0d expected %0d", name, ch, bus.rd_cnt, expv);
        end
    endtask

    task automatic check_pulses(input int got, input int expv, input string name);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: match pulses got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic test_reset();
        int p0;
        reset_L     = 1'b0;
        bus.req     = '1;
        bus.bit_in  = '0;
        bus.clr     = '0;
        bus.rd_sel  = '0;
        sbus.req    = '0;
        sbus.bit_in = '0;
        sbus.clr    = '0;
        sbus.rd_sel = '0;
        model_reset();
        #2;
        total++;
        if (bus.gnt !== 4'b0000) begin
            bad++;
            $display("FAIL reset gnt: got %b expected 0000", bus.gnt);
        end
        total++;
        if (bus.match_valid !== 1'b0 || bus.match_ch !== 2'd0) begin
            bad++;
            $display("FAIL reset match: got valid=%b ch=%0d expected 0/0", bus.match_valid, bus.match_ch);
        end
        for (int i = 0; i < N; i++) check_cnt(i, 0, "reset cnt");
        bus.req = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_L = 1'b1;
        p0 = pulses;
        step(4'b0000, 4'b0000, 4'b0000);
        check_pulses(pulses - p0, 0, "reset idle");
    endtask

    task automatic test_single_channel();
        int p0;
        p0 = pulses;
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000);
        check_pulses(pulses - p0, 1, "single 010");
        check_cnt(0, 1, "single cnt");
    endtask

    task automatic test_overlap();
        int p0;
        int s1 [5] = '{0, 1, 0, 1, 0};
        int s2 [4] = '{0, 1, 1, 0};
        p0 = pulses;
        for (int i = 0; i < 5; i++) step(4'b0100, s1[i] ? 4'b0100 : 4'b0000, 4'b0000);
        check_pulses(pulses - p0, 2, "overlap 01010");
        check_cnt(2, 2, "overlap cnt");
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(4'b0100, s2[i] ? 4'b0100 : 4'b0000, 4'b0000);
        check_pulses(pulses - p0, 0, "overlap 0110");
        check_cnt(2, 2, "overlap cnt hold");
    endtask

    task automatic test_fairness();
        int p0;
        int s0 [3] = '{0, 1, 0};
        do_reset();
        p0 = pulses;
        for (int t = 0; t < 12; t++) step(4'b1111, {3'b111, s0[t / 4] != 0}, 4'b0000);
        check_pulses(pulses - p0, 1, "fairness");
        check_cnt(0, 1, "fairness cnt0");
        check_cnt(1, 0, "fairness cnt1");
    endtask

    task automatic test_saturation();
        int m;
        int sp;
        bit h [$];
        bit expv;
        int ecnt;
        m  = 0;
        sp = 0;
        sbus.req    = 4'b0010;
        sbus.rd_sel = 2'd1;
        for (int i = 0; i < 11; i++) begin
            sbus.bit_in = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            #1;
            total++;
            if (sbus.gnt !== 4'b0010) begin
                bad++;
                $display("FAIL sat gnt: got %b expected 0010", sbus.gnt);
            end
            h.push_back(i % 2 == 1);
            if (h.size() > 3) void'(h.pop_front());
            expv = (h.size() == 3 && h[0] == 1'b0 && h[1] == 1'b1 && h[2] == 1'b0);
            if (expv) m++;
            ecnt = (m > 3) ? 3 : m;
            @(posedge clock);
            #1;
            if (sbus.match_valid === 1'b1) sp++;
            total++;
            if (sbus.match_valid !== expv) begin
                bad++;
                $display("FAIL sat match_valid: bit %0d got %b expected %b", i, sbus.match_valid, expv);
            end
            total++;
            if (sbus.rd_cnt !== 2'(ecnt)) begin
                bad++;
                $display("FAIL sat rd_cnt: bit %0d got %0d expected %0d", i, sbus.rd_cnt, ecnt);
            end
        end
        sbus.req = '0;
        check_pulses(sp, 5, "sat pulses");
    endtask

    task automatic test_clr_collision();
        int p0;
        int c0;
        p0 = pulses;
        c0 = cnt_m[0];
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        check_pulses(pulses - p0, 1, "clr setup");
        check_cnt(0, c0 + 1, "clr setup cnt");
        p0 = pulses;
        step(4'b0011, {2'b00, 1'($urandom_range(0, 1)), 1'b0}, 4'b0001);
        check_cnt(0, 0, "clr cnt");
        step(4'b0001, 4'b0000, 4'b0000);
        check_pulses(pulses - p0, 0, "clr no match");
    endtask

    task automatic test_async_reset();
        int p0;
        for (int i = 0; i < 3; i++) step(4'b0100, (i == 1) ? 4'b0100 : 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        bus.req    = 4'b1111;
        bus.bit_in = 4'b1110;
        reset_L    = 1'b0;
        model_reset();
        #2;
        total++;
        if (bus.gnt !== 4'b0000) begin
            bad++;
            $display("FAIL async reset gnt: got %b expected 0000", bus.gnt);
        end
        for (int i = 0; i < N; i++) check_cnt(i, 0, "async reset cnt");
        @(posedge clock);
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.match_valid !== 1'b0) begin
            bad++;
            $display("FAIL async reset hold: gnt=%b match_valid=%b expected 0000/0", bus.gnt, bus.match_valid);
        end
        reset_L = 1'b1;
        p0 = pulses;
        step(4'b1111, 4'b1110, 4'b0000);
        check_pulses(pulses - p0, 0, "async reset 3rd bit");
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] b;
        logic [N-1:0] c;
        for (int t = 0; t < 400; t++) begin
            r = N'($urandom);
            b = N'($urandom);
            c = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) c[i] = 1'b1;
            step(r, b, c);
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_single_channel();
        test_overlap();
        test_fairness();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/det010_rr_sched.md
Name: det010_rr_sched

Overview:
Shares one "0-1-0" serial pattern detector (overlapping detection) among N_CH independent serial bit-stream requesters. Each channel keeps its own saved detector context. A round-robin arbiter grants one channel per cycle. The shared next-state logic advances the granted channel's context, flags matches, and keeps a saturating match count per channel. It sits between the serial-input sources and the status/readback logic.

Parameters:
N_CH, 4, number of requesting channels (>=2)
CNT_W, 8, width of each per-channel saturating match counter

Ports:
clock  input  1  system clock, rising-edge
reset_L  input  1  reset, asynchronous, active-low
req  input  N_CH  per-channel request; channel offers one bit this cycle
bit_in  input  N_CH  per-channel serial data bit, valid while req[i]=1
clr  input  N_CH  per-channel synchronous clear of context and counter
gnt  output  N_CH  one-hot (or zero) grant; combinational from req, clr, ptr
match_valid  output  1  registered one-cycle pulse: granted bit completed 0-1-0
match_ch  output  $clog2(N_CH)  channel index of the match; valid with match_valid
rd_sel  input  $clog2(N_CH)  counter readback select
rd_cnt  output  CNT_W  combinational: cnt[rd_sel]

Behaviour:
- Reset (async, reset_L=0): ctx[i]=IDLE, cnt[i]=0, ptr=0, match_valid=0, match_ch=0. gnt forced to 0 while reset_L=0. Mid-stream reset discards all partial progress immediately.
- Context encoding, 2 bits per channel: IDLE=00 (no progress), S0=01 (last bit 0), S01=10 (last bits 0,1), S010=11 (last bits 0,1,0).
- Transitions on an accepted bit b:
  - IDLE: b=0 -> S0; b=1 -> IDLE.
  - S0: 0 -> S0; 1 -> S01.
  - S01: 0 -> S010; 1 -> IDLE.
  - S010: 0 -> S0; 1 -> S01 (overlap allowed).
- Eligibility: eligible[i] = req[i] & ~clr[i].
- Grant: the first eligible channel at or after ptr, searching cyclically upward. At most one gnt bit is set. No eligible channel -> gnt=0.
- On grant to channel k (rising edge):
  - ctx[k] <= next(ctx[k], bit_in[k]).
  - ptr <= (k+1) mod N_CH.
- With no grant, ptr holds.
- Channels that are not granted hold their context. Their bit is not consumed: the requester holds req and bit_in stable until it sees gnt.
- Match: if next(ctx[k], bit_in[k]) == S010 at a grant, then on the following cycle match_valid=1 and match_ch=k. Otherwise match_valid=0. Latency is 1 cycle from the grant edge. match_ch holds its last value when match_valid=0.
- Counter: cnt[k] increments on the same edge that registers the match. It saturates at 2^CNT_W-1 and never wraps.
- clr[i] (synchronous): ctx[i] <= IDLE and cnt[i] <= 0. A cleared channel is excluded from arbitration that cycle, so there is no grant, no bit consumption and no match. ptr is unaffected by a cleared channel.
- Simultaneous clr on several channels is independent per channel. clr on one channel does not block grants to others.
- rd_cnt reflects registered cnt values and shows a change 1 cycle after the incrementing or clearing edge.
- A single shared next-state/match datapath instance, muxed by the grant index; not replicated per channel.

Test Plan:
- Single channel: req[0]=1 continuously with bit_in[0]=0,1,0 -> gnt[0] every cycle; match_valid=1, match_ch=0 exactly one cycle after the 3rd grant; rd_sel=0 gives rd_cnt=1.
- Overlap: ch2 stream 0,1,0,1,0 -> match_valid pulses after the 3rd and 5th grants, cnt[2]=2; stream 0,1,1,0 -> no match.
- Fairness/interleave: all req=1 from reset -> gnt sequence ch0,ch1,ch2,ch3,ch0. With ch0 bits 0,1,0 and ch1 bits 1,1,1 on their successive grants, ch0 matches once after its 3rd grant (overall grant 9); ch1 never matches; contexts do not cross-contaminate.
- Saturation (CNT_W=2): 5 matches on ch1 -> rd_cnt sequence 1,2,3,3,3; match_valid still pulses all 5 times.
- clr collision: ch0 in S01, req[0]=1 with bit 0 and clr[0]=1 in the same cycle -> gnt[0]=0, no match, ctx[0]=IDLE, cnt[0]=0. ch1 requesting in the same cycle is granted.
- Async reset mid-stream: drop reset_L between bit 2 and bit 3 of a 0,1,0 stream -> gnt=0 during reset. After release the 3rd bit (0) gives S0, no match; ptr=0, all counters 0.
